// File: rtl/tow_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tow_pkg: shared state encoding, score limit and LED bar sizing       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package tow_pkg;

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_WIN_L = 2'd1;
  localparam logic [1:0] ST_WIN_R = 2'd2;

  typedef enum logic [1:0] {
    PLAY  = ST_PLAY,
    WIN_L = ST_WIN_L,
    WIN_R = ST_WIN_R
  } tow_state_e;

  localparam int SCORE_MAX = 9;

  function automatic int led_width(input int half);
    return 2 * half + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/blink_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blink_timer: square-wave phase, BLINK_CYC cycles per half-period      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module blink_timer #(
  parameter int BLINK_CYC = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic phase
);

  localparam int CNT_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BLINK_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  // Phase restarts high so the end LED lights immediately on a win.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (en) begin
      if (r_cnt == C_CNT_LAST) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/tow_referee.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tow_referee: tug-of-war marker, round win detection, scores, blink    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tow_referee
  import tow_pkg::*;
#(
  parameter int HALF      = 4,
  parameter int BLINK_CYC = 25_000_000,
  parameter int SCORE_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pl,
  input  logic                         pr,
  input  logic                         newgame,
  output logic [led_width(HALF)-1:0]   leds,
  output logic [SCORE_W-1:0]           scorel,
  output logic [SCORE_W-1:0]           scorer,
  output logic                         winl,
  output logic                         winr
);

  localparam int LED_W = led_width(HALF);
  localparam int IDX_W = $clog2(LED_W);
  localparam logic [IDX_W-1:0]   C_IDX_CENTRE = IDX_W'(HALF);
  localparam logic [IDX_W-1:0]   C_IDX_PRE_L  = IDX_W'(2 * HALF - 1);
  localparam logic [IDX_W-1:0]   C_IDX_PRE_R  = IDX_W'(1);
  localparam logic [SCORE_W-1:0] C_SCORE_MAX  = SCORE_W'(SCORE_MAX);

  tow_state_e       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [SCORE_W-1:0] r_scorel;
  logic [SCORE_W-1:0] r_scorer;
  logic             w_step_l;
  logic             w_step_r;
  logic             w_phase;
  logic [LED_W-1:0] w_leds;

  // Simultaneous pushes cancel out.
  assign w_step_l = pl & ~pr;
  assign w_step_r = pr & ~pl;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= PLAY;
      r_idx    <= C_IDX_CENTRE;
      r_scorel <= '0;
      r_scorer <= '0;
    end else if (newgame) begin
      r_state <= PLAY;
      r_idx   <= C_IDX_CENTRE;
    end else if (r_state == PLAY) begin
      if (w_step_l) begin
        r_idx <= r_idx + 1'b1;
        if (r_idx == C_IDX_PRE_L) begin
          r_state <= WIN_L;
          if (r_scorel != C_SCORE_MAX) r_scorel <= r_scorel + 1'b1;
        end
      end else if (w_step_r) begin
        r_idx <= r_idx - 1'b1;
        if (r_idx == C_IDX_PRE_R) begin
          r_state <= WIN_R;
          if (r_scorer != C_SCORE_MAX) r_scorer <= r_scorer + 1'b1;
        end
      end
    end
  end

  // Held clear throughout play so the win entry edge starts a fresh blink.
  blink_timer #(
    .BLINK_CYC (BLINK_CYC)
  ) u_blink (
    .clk   (clk),
    .rst   (rst),
    .clr   ((r_state == PLAY) | newgame),
    .en    (r_state != PLAY),
    .phase (w_phase)
  );

  always_comb begin
    w_leds = '0;
    case (r_state)
      WIN_L:   w_leds[LED_W-1] = w_phase;
      WIN_R:   w_leds[0]       = w_phase;
      default: w_leds          = LED_W'(1) << r_idx;
    endcase
  end

  assign leds   = w_leds;
  assign scorel = r_scorel;
  assign scorer = r_scorer;
  assign winl   = (r_state == WIN_L);
  assign winr   = (r_state == WIN_R);

endmodule
`default_nettype wire

// File: tb/tb_tow_referee.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tow_referee: directed plus random pushes against a position model |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_tow_referee;

  localparam int HALF  = 4;
  localparam int BLINK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pl = 1'b0;
  logic       pr = 1'b0;
  logic       newgame = 1'b0;
  logic [8:0] leds;
  logic [3:0] scorel;
  logic [3:0] scorer;
  logic       winl;
  logic       winr;

  int vectors = 0;
  int fails   = 0;

  // Model: 0 = playing, 1 = left won, 2 = right won; t = cycles since win.
  int m_mode = 0;
  int m_pos  = HALF;
  int m_sl   = 0;
  int m_sr   = 0;
  int m_t    = 0;

  always #5 clk = ~clk;

  tow_referee #(
    .HALF      (HALF),
    .BLINK_CYC (BLINK),
    .SCORE_W   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pl      (pl),
    .pr      (pr),
    .newgame (newgame),
    .leds    (leds),
    .scorel  (scorel),
    .scorer  (scorer),
    .winl    (winl),
    .winr    (winr)
  );

  task automatic model_edge(input logic a_rst, input logic a_pl, input logic a_pr, input logic a_ng);
    if (!a_rst) begin
      m_mode = 0; m_pos = HALF; m_sl = 0; m_sr = 0; m_t = 0;
    end else if (a_ng) begin
      m_mode = 0; m_pos = HALF; m_t = 0;
    end else if (m_mode == 0) begin
      if (a_pl && !a_pr) m_pos = m_pos + 1;
      else if (a_pr && !a_pl) m_pos = m_pos - 1;
      if (m_pos == 2 * HALF) begin
        m_mode = 1; m_t = 0; m_sl = (m_sl < 9) ? m_sl + 1 : 9;
      end else if (m_pos == 0) begin
        m_mode = 2; m_t = 0; m_sr = (m_sr < 9) ? m_sr + 1 : 9;
      end
    end else begin
      m_t = m_t + 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [8:0] e_leds;
    logic       lit;
    lit = ((m_t / BLINK) % 2) == 0;
    if (m_mode == 0)      e_leds = 9'(1) << m_pos;
    else if (!lit)        e_leds = 9'h000;
    else if (m_mode == 1) e_leds = 9'h100;
    else                  e_leds = 9'h001;
    vectors += 5;
    assert (leds === e_leds) else begin
      fails++; $error("FAIL %s leds observed=%b expected=%b", tag, leds, e_leds);
    end
    assert (winl === (m_mode == 1)) else begin
      fails++; $error("FAIL %s winl observed=%b expected=%0d", tag, winl, m_mode == 1);
    end
    assert (winr === (m_mode == 2)) else begin
      fails++; $error("FAIL %s winr observed=%b expected=%0d", tag, winr, m_mode == 2);
    end
    assert (scorel === 4'(m_sl)) else begin
      fails++; $error("FAIL %s scorel observed=%0d expected=%0d", tag, scorel, m_sl);
    end
    assert (scorer === 4'(m_sr)) else begin
      fails++; $error("FAIL %s scorer observed=%0d expected=%0d", tag, scorer, m_sr);
    end
  endtask

  task automatic step(input string tag, input logic a_rst, input logic a_pl, input logic a_pr, input logic a_ng);
    rst = a_rst; pl = a_pl; pr = a_pr; newgame = a_ng;
    @(posedge clk);
    model_edge(a_rst, a_pl, a_pr, a_ng);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset held for two edges
    step("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Left win with pulses one idle cycle apart, then ignored pushes
    for (int i = 0; i < 4; i++) begin
      step("walk_left", 1'b1, 1'b1, 1'b0, 1'b0);
      step("walk_left_gap", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step("won_pl", 1'b1, 1'b1, 1'b0, 1'b0);
    step("won_pr", 1'b1, 1'b0, 1'b1, 1'b0);

    // Blink pattern over three half-periods
    for (int i = 0; i < 12; i++) step("blink", 1'b1, 1'b0, 1'b0, 1'b0);

    // newgame beats a same-cycle pl; then simultaneous push and right win
    step("newgame_pl", 1'b1, 1'b1, 1'b0, 1'b1);
    step("both", 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("walk_right", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step("blink_r", 1'b1, 1'b0, 1'b0, 1'b0);

    // Ten more left wins saturate scorel
    for (int w = 0; w < 10; w++) begin
      step("sat_ng", 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step("sat_walk", 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Mid-round reset with scorel=3 and marker at 6
    step("pre_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      step("pre_ng", 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step("pre_walk", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    step("pre_ng", 1'b1, 1'b0, 1'b0, 1'b1);
    step("pre_walk", 1'b1, 1'b1, 1'b0, 1'b0);
    step("pre_walk", 1'b1, 1'b1, 1'b0, 1'b0);
    step("mid_rst", 1'b0, 1'b1, 1'b0, 1'b0);

    // Random pushes, occasional newgame and reset
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 199);
      step("random", (r >= 2), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), (r >= 2 && r < 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tow_referee.md
# tow_referee

Tug-of-war game core: consumes the single-cycle push pulses produced by the per-player one-push-per-pulse stages, moves a rope marker along an LED bar, detects a round win, blinks the winner's end LED and keeps per-player round scores. Sits directly downstream of the two push-to-pulse stages and drives the LED bar and score displays.

## Interface
- `HALF`, 4: marker steps from centre to either end; LED bar width is 2*HALF+1.
- `BLINK_CYC`, 25_000_000: clock cycles per blink half-period in a win state; must be ≥1.
- `SCORE_W`, 4: score width; the saturation value SCORE_MAX is 9.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-low reset; low at a posedge resets everything.
- `pl`  in  1  left-player push pulse, one cycle wide.
- `pr`  in  1  right-player push pulse, one cycle wide.
- `newgame`  in  1  pulse: start a new round, keeping scores.
- `leds`  out  2*HALF+1  one-hot marker bar; bit 2*HALF = left end, bit 0 = right end.
- `scorel`, `scorer`  out  SCORE_W  rounds won by each player.
- `winl`, `winr`  out  1  high while in WIN_L / WIN_R.

## Operation
- Registers: `idx` (0..2*HALF), `state` ∈ {PLAY, WIN_L, WIN_R}, two score counters, blink counter and phase.
- Reset: state=PLAY, idx=HALF, scores=0, blink counter=0, phase=1. Outputs then: leds = only bit HALF set, scores 0, winl=winr=0.
- PLAY: pl alone → idx+1; pr alone → idx−1; pl and pr together → no move; neither → hold.
- idx reaching 2*HALF → WIN_L, scorel+1; idx reaching 0 → WIN_R, scorer+1. Score increments saturate at 9 and never wrap.
- WIN_L/WIN_R: pl and pr are ignored. The end LED (bit 2*HALF or bit 0) is gated by the blink phase. On win entry, phase=1 and counter=0. Phase toggles each time the counter reaches BLINK_CYC−1, and the counter then returns to 0.
- `newgame` in any state: state=PLAY, idx=HALF, scores unchanged, blink logic reset. newgame has priority over pl and pr in the same cycle.
- leds in PLAY: one-hot at idx. leds in a win state: end bit & phase, all other bits 0.

## Timing
- All state is registered. leds, winl and winr are combinational decodes of registers only, with no input-to-output paths.
- A pulse sampled at edge n is reflected in leds, and in winl/winr/score when the round ends, from edge n onward, i.e. one cycle after the pulse is asserted.
- Consecutive pulses on back-to-back cycles each count, so no lockout is applied.
- Reset mid-round or mid-blink fully restores reset values at that edge.
- Pulses wider than one cycle are not expected. If they occur, each high cycle counts as one step.

## Structure
- Shared package `tow_pkg` holds:
  - the state enum (PLAY, WIN_L, WIN_R);
  - `SCORE_MAX = 9`;
  - a helper function for the LED bar width, 2*HALF+1.
- Sub-module `blink_timer` (params BLINK_CYC):
  - inputs: clk, rst, clr, en;
  - output: phase;
  - instantiated once.
- Everything else lives in tow_referee.

## Test plan
Bench uses HALF=4 and BLINK_CYC=4.
- **Reset:** hold rst=0 for 2 cycles → leds=9'b000010000, scores 0, winl=winr=0.
- **Left win:** 4 pl pulses, one cycle apart → leds walks bit 5, 6, 7, 8. winl=1 and scorel=1 on the edge after the 4th pulse. Further pl/pr pulses change nothing.
- **Simultaneous pushes:** pl=pr=1 for one cycle from centre → leds stays bit 4. Then pr, pr, pr, pr → leds reaches bit 0 and winr=1, scorer=1.
- **Blink:** in WIN_L, leds[8] is 1 for 4 cycles, 0 for 4, 1 for 4. All other bits stay 0 throughout.
- **newgame and scores:**
  - newgame with pl in the same cycle → state PLAY, leds bit 4, no step taken, scores retained.
  - 10 left wins → scorel saturates at 9.
- **Mid-round reset:** rst=0 while idx=6 and scorel=3 → idx=4, scorel=0 at that edge.
